// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries execute results into the memory stage and
// feeds the madd/msub partial product and cycle counter back to execute.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic        ex_cp0_reg_we,
  input  logic [4:0]  ex_cp0_reg_write_addr,
  input  logic [31:0] ex_cp0_reg_data,
  input  logic [31:0] ex_excepttype,
  input  logic        ex_is_in_delayslot,
  input  logic [31:0] ex_current_inst_address,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_mem_addr,
  output logic [31:0] mem_reg2,
  output logic        mem_cp0_reg_we,
  output logic [4:0]  mem_cp0_reg_write_addr,
  output logic [31:0] mem_cp0_reg_data,
  output logic [31:0] mem_excepttype,
  output logic        mem_is_in_delayslot,
  output logic [31:0] mem_current_inst_address,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_data;
    logic [31:0] excepttype;
    logic        dslot;
    logic [31:0] pc;
  } stage_t;

  stage_t ex_s, mem_q;

  // Only the execute and memory stall bits matter to this register.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  assign ex_s = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
                 ex_mem_addr, ex_reg2, ex_cp0_reg_we, ex_cp0_reg_write_addr,
                 ex_cp0_reg_data, ex_excepttype, ex_is_in_delayslot,
                 ex_current_inst_address};

  assign {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
          mem_mem_addr, mem_reg2, mem_cp0_reg_we, mem_cp0_reg_write_addr,
          mem_cp0_reg_data, mem_excepttype, mem_is_in_delayslot,
          mem_current_inst_address} = mem_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_q  <= '0;
      hilo_o <= '0;
      cnt_o  <= 2'b00;
    end else if (!stall[3]) begin
      // stall[4] without stall[3] is illegal upstream and lands here as advance.
      mem_q  <= ex_s;
      hilo_o <= '0;
      cnt_o  <= 2'b00;
    end else if (!stall[4]) begin
      // Bubble into memory while execute keeps iterating its madd/msub.
      mem_q  <= '0;
      hilo_o <= hilo_i;
      cnt_o  <= cnt_i;
    end
  end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have no parameters; widths are fixed: register bus 32, register address 5, ALU op 8, HI/LO pair 64.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ex_wd  in  5  destination GPR address from execute.
REQ-005 ex_wreg  in  1  GPR write enable from execute.
REQ-006 ex_wdata  in  32  GPR write data from execute.
REQ-007 ex_hi / ex_lo / ex_whilo  in  32/32/1  HI/LO values and write enable.
REQ-008 ex_aluop  in  8  ALU op code, which memory uses to select load/store kind.
REQ-009 ex_mem_addr / ex_reg2  in  32/32  load/store effective address; store data.
REQ-010 ex_cp0_reg_we / ex_cp0_reg_write_addr / ex_cp0_reg_data  in  1/5/32  CP0 write request.
REQ-011 ex_excepttype / ex_is_in_delayslot / ex_current_inst_address  in  32/1/32  exception info.
REQ-012 stall  in  6  per-stage stall vector from control; bit 3 = execute, bit 4 = memory.
REQ-013 flush  in  1  pipeline flush from control on exception.
REQ-014 hilo_i / cnt_i  in  64/2  madd/msub first-cycle partial product and cycle counter from execute.
REQ-015 mem_* outputs  out  same widths as ex_* inputs  registered copies: mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2, mem_cp0_reg_we, mem_cp0_reg_write_addr, mem_cp0_reg_data, mem_excepttype, mem_is_in_delayslot, mem_current_inst_address.
REQ-016 hilo_o / cnt_o  out  64/2  partial product and counter fed back to execute.

Function
REQ-017 Every output SHALL be a flop written only on rising clk; no combinational paths from input to output.
REQ-018 Update priority per edge SHALL be: rst, then flush, then bubble, then advance, then hold.
REQ-019 rst=1: all outputs cleared to 0: addresses 5'b00000, enables WriteDisable (0), data/addresses/excepttype 32'h0, hilo_o 64'h0, cnt_o 2'b00.
REQ-020 flush=1 (rst=0): all mem_* cleared as in reset; hilo_o and cnt_o also cleared, which abandons any in-flight madd/msub.
REQ-021 Bubble (stall[3]=1, stall[4]=0): all mem_* cleared to reset values; hilo_o<=hilo_i and cnt_o<=cnt_i, so execute resumes a multi-cycle op next cycle.
REQ-022 Advance (stall[3]=0): every mem_* <= corresponding ex_*; hilo_o<=0; cnt_o<=2'b00.
REQ-023 Hold (stall[3]=1, stall[4]=1): all outputs, including hilo_o and cnt_o, retain their values.
REQ-024 stall[3]=0 with stall[4]=1 is illegal from control; the block SHALL treat it as advance. Verification flags it as a protocol error.
REQ-025 Latency: exactly one cycle from ex_* to mem_* on advance.
REQ-026 The block performs no arithmetic; values pass through bit-exact with no width change.
REQ-027 flush coincident with any stall pattern SHALL clear. flush coincident with rst SHALL reset; both give identical values.
REQ-028 ex_excepttype nonzero SHALL propagate unchanged; the block does not itself suppress the writes (memory stage does).

Reset
REQ-029 Reset SHALL take effect at the first rising edge with rst=1 and hold while asserted, independent of stall/flush.
REQ-030 Reset asserted mid madd/msub (cnt_o=2'b01) SHALL clear cnt_o and hilo_o on that edge.
REQ-031 First advance after rst deasserts SHALL capture ex_* normally; no extra dead cycle.

Verification
REQ-032 Advance: stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h12345678 -> next edge mem_wd=3, mem_wreg=1, mem_wdata=32'h12345678, cnt_o=0.
REQ-033 Madd bubble: stall=6'b001111, hilo_i=64'hFFFF_0000_0000_0001, cnt_i=2'b01 -> mem_wreg=0, mem_wdata=0, hilo_o=64'hFFFF_0000_0000_0001, cnt_o=2'b01; next cycle stall=0 -> cnt_o=0.
REQ-034 Hold: preload mem_wdata=32'hA5A5A5A5, then stall=6'b011111 for 3 cycles with changing ex_* -> mem_wdata stays 32'hA5A5A5A5.
REQ-035 Flush: mem_excepttype=32'h8, cnt_o=1 pending, flush=1 with stall=6'b001111 -> all outputs 0 next edge.
REQ-036 Reset mid-stream: rst=1 for one edge while stall=0 and ex_wdata=32'hDEADBEEF -> all outputs 0; rst=0 next edge -> mem_wdata=32'hDEADBEEF.
